xt_lbus_arbiter: RTL and testbench

//  Shares the 8-bit local bus (LB) between NUM_MASTER requesters using round-robin arbitration.

---
 rtl/xt_lbus_arbiter_if.sv | 35 +++
 rtl/xt_lbus_arbiter.sv | 101 ++++++++++
 tb/tb_xt_lbus_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xt_lbus_arbiter_if.sv
// Local-bus bundle between the LB masters, the arbiter and the LB slaves.
// The arbiter connects through the slave modport; masters and slave models use master.
interface xt_lbus_arbiter_if #(
   parameter int NUM_MASTER = 2
);
   localparam int NUM_SLAVE = 4;

   typedef struct packed {
      logic [5:0]  offset;
      logic [1:0]  write_width;
      logic [31:0] wdata;
   } lb_slave_t;

   logic [NUM_MASTER-1:0]        m_req;
   logic [NUM_MASTER-1:0]        m_we;
   logic [NUM_MASTER-1:0][7:0]   m_addr;
   logic [NUM_MASTER-1:0][1:0]   m_write_width;
   logic [NUM_MASTER-1:0][31:0]  m_wdata;
   logic [NUM_MASTER-1:0]        m_ready;
   logic [31:0]                  m_rdata;
   lb_slave_t                    lb_slave;
   logic [NUM_SLAVE-1:0]         s_re;
   logic [NUM_SLAVE-1:0]         s_we;
   logic [NUM_SLAVE-1:0][31:0]   s_rdata;

   modport slave (
      input  m_req, m_we, m_addr, m_write_width, m_wdata, s_rdata,
      output m_ready, m_rdata, lb_slave, s_re, s_we
   );

   modport master (
      output m_req, m_we, m_addr, m_write_width, m_wdata, s_rdata,
      input  m_ready, m_rdata, lb_slave, s_re, s_we
   );
endinterface

// File: rtl/xt_lbus_arbiter.sv
// Round-robin local-bus arbiter: grants one master per access, strobes the addressed
// slave for one cycle, then returns a one-cycle ready with read data.
//
// state  | meaning
// IDLE   | arbitrate pending requests, capture the winner's access
// ACCESS | one-cycle s_re/s_we strobe to the decoded slave
// RESP   | one-cycle m_ready to the winner, read data on m_rdata
module xt_lbus_arbiter #(
   parameter int NUM_MASTER = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   xt_lbus_arbiter_if.slave  bus
);
   localparam int GW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

   typedef logic [GW-1:0] grant_t;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [NUM_MASTER-1:0] ONE_M = 1;

   state_t      state;
   grant_t      grant;
   grant_t      last_grant;
   grant_t      next_grant;
   grant_t      cand;
   logic        req_any;
   logic [1:0]  id;
   logic        we;
   logic [31:0] rdata_hold;

   // Scan from farthest to nearest after last_grant so the nearest requester wins.
   always_comb begin
      req_any    = 1'b0;
      next_grant = '0;
      cand       = '0;
      for (int i = NUM_MASTER; i >= 1; i--) begin
         cand = grant_t'((int'(last_grant) + i) % NUM_MASTER);
         if (bus.m_req[cand]) begin
            req_any    = 1'b1;
            next_grant = cand;
         end
      end
   end

   // Read data is only valid from the slave during RESP, so it is forwarded
   // combinationally then and held afterwards.
   always_comb begin
      if (state == RESP) bus.m_rdata = we ? 32'h0 : bus.s_rdata[id];
      else               bus.m_rdata = rdata_hold;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= '0;
         last_grant   <= grant_t'(NUM_MASTER - 1);
         id           <= '0;
         we           <= 1'b0;
         rdata_hold   <= '0;
         bus.lb_slave <= '0;
         bus.s_re     <= '0;
         bus.s_we     <= '0;
         bus.m_ready  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  grant                    <= next_grant;
                  id                       <= bus.m_addr[next_grant][7:6];
                  we                       <= bus.m_we[next_grant];
                  bus.lb_slave.offset      <= bus.m_addr[next_grant][5:0];
                  bus.lb_slave.write_width <= bus.m_write_width[next_grant];
                  bus.lb_slave.wdata       <= bus.m_wdata[next_grant];
                  bus.s_we <= bus.m_we[next_grant] ? (4'b0001 << bus.m_addr[next_grant][7:6]) : 4'b0000;
                  bus.s_re <= bus.m_we[next_grant] ? 4'b0000 : (4'b0001 << bus.m_addr[next_grant][7:6]);
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               bus.s_re    <= '0;
               bus.s_we    <= '0;
               bus.m_ready <= ONE_M << grant;
               state       <= RESP;
            end
            RESP: begin
               bus.m_ready <= '0;
               last_grant  <= grant;
               rdata_hold  <= bus.m_rdata;
               state       <= IDLE;
            end
            default: begin
               bus.s_re    <= '0;
               bus.s_we    <= '0;
               bus.m_ready <= '0;
               state       <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_xt_lbus_arbiter.sv
// Bench for xt_lbus_arbiter: directed scenarios plus a randomized run against a
// cycle-timed transaction model of the arbitration and latency rules.
module tb_xt_lbus_arbiter;
   localparam int NM = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;

   xt_lbus_arbiter_if #(.NUM_MASTER(NM)) bus ();
   xt_lbus_arbiter #(.NUM_MASTER(NM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0;
      bus.m_req = '0;
      bus.m_we = '0;
      bus.m_addr = '0;
      bus.m_write_width = '0;
      bus.m_wdata = '0;
      for (int s = 0; s < 4; s++) bus.s_rdata[s] = $urandom;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++;
      if ({bus.s_re, bus.s_we, bus.m_ready} !== 10'h0) begin
         bad++; $display("FAIL reset_strobes: got %h want 0", {bus.s_re, bus.s_we, bus.m_ready});
      end
      total++;
      if (bus.m_rdata !== 32'h0) begin
         bad++; $display("FAIL reset_rdata: got %h want 0", bus.m_rdata);
      end
      total++;
      if (bus.lb_slave !== 40'h0) begin
         bad++; $display("FAIL reset_lb_slave: got %h want 0", bus.lb_slave);
      end
   endtask

   task automatic test_single_write();
      do_reset();
      @(posedge clk); #1;
      bus.m_req = 2'b01; bus.m_we = 2'b01; bus.m_addr[0] = 8'h45;
      bus.m_write_width[0] = 2'b10; bus.m_wdata[0] = 32'hDEADBEEF;
      @(negedge clk);
      total++;
      if ({bus.s_re, bus.s_we, bus.m_ready} !== 10'h0) begin
         bad++; $display("FAIL wr_idle: got %h want 0", {bus.s_re, bus.s_we, bus.m_ready});
      end
      @(negedge clk);
      total++;
      if ({bus.s_re, bus.s_we, bus.m_ready} !== {4'b0000, 4'b0010, 2'b00}) begin
         bad++; $display("FAIL wr_strobe: got %h want %h", {bus.s_re, bus.s_we, bus.m_ready}, {4'b0000, 4'b0010, 2'b00});
      end
      total++;
      if (bus.lb_slave !== {6'h05, 2'b10, 32'hDEADBEEF}) begin
         bad++; $display("FAIL wr_lb_slave: got %h want %h", bus.lb_slave, {6'h05, 2'b10, 32'hDEADBEEF});
      end
      @(negedge clk);
      total++;
      if ({bus.s_re, bus.s_we, bus.m_ready} !== {8'h00, 2'b01}) begin
         bad++; $display("FAIL wr_ready: got %h want %h", {bus.s_re, bus.s_we, bus.m_ready}, {8'h00, 2'b01});
      end
      total++;
      if (bus.m_rdata !== 32'h0) begin
         bad++; $display("FAIL wr_rdata_zero: got %h want 0", bus.m_rdata);
      end
      total++;
      if (bus.lb_slave !== {6'h05, 2'b10, 32'hDEADBEEF}) begin
         bad++; $display("FAIL wr_lb_stable: got %h want %h", bus.lb_slave, {6'h05, 2'b10, 32'hDEADBEEF});
      end
      @(posedge clk); #1;
      bus.m_req = '0;
      @(negedge clk);
      total++;
      if (bus.m_ready !== 2'b00) begin
         bad++; $display("FAIL wr_ready_once: got %b want 00", bus.m_ready);
      end
   endtask

   task automatic test_single_read();
      do_reset();
      bus.s_rdata[3] = 32'h1234_5678;
      @(posedge clk); #1;
      bus.m_req = 2'b10; bus.m_we = 2'b00; bus.m_addr[1] = 8'hC3;
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({bus.s_re, bus.s_we} !== {4'b1000, 4'b0000}) begin
         bad++; $display("FAIL rd_strobe: got %h want %h", {bus.s_re, bus.s_we}, {4'b1000, 4'b0000});
      end
      total++;
      if (bus.lb_slave.offset !== 6'h03) begin
         bad++; $display("FAIL rd_offset: got %h want 03", bus.lb_slave.offset);
      end
      @(negedge clk);
      total++;
      if (bus.m_ready !== 2'b10) begin
         bad++; $display("FAIL rd_ready: got %b want 10", bus.m_ready);
      end
      total++;
      if (bus.m_rdata !== 32'h1234_5678) begin
         bad++; $display("FAIL rd_rdata: got %h want 12345678", bus.m_rdata);
      end
      @(posedge clk); #1;
      bus.m_req = '0;
      bus.s_rdata[3] = 32'hFFFF_0000;
      @(negedge clk);
      total++;
      if (bus.m_rdata !== 32'h1234_5678) begin
         bad++; $display("FAIL rd_hold: got %h want 12345678", bus.m_rdata);
      end
   endtask

   task automatic test_contention();
      logic [9:0] exp;
      int j;
      do_reset();
      @(posedge clk); #1;
      bus.m_req = 2'b11; bus.m_we = 2'b11;
      bus.m_addr[0] = 8'h01; bus.m_addr[1] = 8'h81;
      for (int n = 0; n < 13; n++) begin
         @(negedge clk);
         exp = '0;
         j = (n - 1) / 3;
         if (n % 3 == 1) exp[5:2] = (j % 2 == 1) ? 4'b0100 : 4'b0001;
         if (n % 3 == 2) exp[1:0] = (j % 2 == 1) ? 2'b10 : 2'b01;
         total++;
         if ({bus.s_re, bus.s_we, bus.m_ready} !== exp) begin
            bad++; $display("FAIL contention_cyc%0d: got %h want %h", n, {bus.s_re, bus.s_we, bus.m_ready}, exp);
         end
      end
      @(posedge clk); #1;
      bus.m_req = '0;
   endtask

   task automatic test_late_request();
      do_reset();
      bus.s_rdata[3] = 32'hCAFE_F00D;
      @(posedge clk); #1;
      bus.m_req = 2'b01; bus.m_we = 2'b01; bus.m_addr[0] = 8'h40;
      bus.m_write_width[0] = 2'b01; bus.m_wdata[0] = 32'hAAAA_5555;
      @(negedge clk);
      @(posedge clk); #1;
      bus.m_req = 2'b11; bus.m_we = 2'b01; bus.m_addr[1] = 8'hC2; bus.m_wdata[1] = 32'h1111_2222;
      @(negedge clk);
      total++;
      if ({bus.s_re, bus.s_we} !== 8'b0000_0010) begin
         bad++; $display("FAIL late_m0_strobe: got %h want 02", {bus.s_re, bus.s_we});
      end
      @(negedge clk);
      total++;
      if (bus.m_ready !== 2'b01) begin
         bad++; $display("FAIL late_m0_ready: got %b want 01", bus.m_ready);
      end
      total++;
      if (bus.lb_slave !== {6'h00, 2'b01, 32'hAAAA_5555}) begin
         bad++; $display("FAIL late_m0_lb_stable: got %h want %h", bus.lb_slave, {6'h00, 2'b01, 32'hAAAA_5555});
      end
      @(posedge clk); #1;
      bus.m_req = 2'b10;
      @(negedge clk);
      total++;
      if ({bus.s_re, bus.s_we, bus.m_ready} !== 10'h0) begin
         bad++; $display("FAIL late_idle: got %h want 0", {bus.s_re, bus.s_we, bus.m_ready});
      end
      @(negedge clk);
      total++;
      if ({bus.s_re, bus.s_we} !== {4'b1000, 4'b0000} || bus.lb_slave.offset !== 6'h02) begin
         bad++; $display("FAIL late_m1_strobe: got %h/%h want 80/02", {bus.s_re, bus.s_we}, bus.lb_slave.offset);
      end
      @(negedge clk);
      total++;
      if (bus.m_ready !== 2'b10 || bus.m_rdata !== 32'hCAFE_F00D) begin
         bad++; $display("FAIL late_m1_ready: got %b/%h want 10/cafef00d", bus.m_ready, bus.m_rdata);
      end
      @(posedge clk); #1;
      bus.m_req = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(posedge clk); #1;
      bus.m_req = 2'b01; bus.m_we = 2'b01; bus.m_addr[0] = 8'h45; bus.m_wdata[0] = 32'h0BAD_CAFE;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.s_we !== 4'b0010) begin
         bad++; $display("FAIL rstmid_pre_strobe: got %b want 0010", bus.s_we);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bus.s_re, bus.s_we, bus.m_ready} !== 10'h0) begin
         bad++; $display("FAIL rstmid_drop: got %h want 0", {bus.s_re, bus.s_we, bus.m_ready});
      end
      total++;
      if (bus.lb_slave !== 40'h0) begin
         bad++; $display("FAIL rstmid_lb: got %h want 0", bus.lb_slave);
      end
      bus.m_req = 2'b11; bus.m_we = 2'b11; bus.m_addr[1] = 8'h81;
      @(negedge clk);
      total++;
      if (bus.m_ready !== 2'b00) begin
         bad++; $display("FAIL rstmid_no_ready: got %b want 00", bus.m_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (bus.s_we !== 4'b0010) begin
         bad++; $display("FAIL rstmid_m0_first: got %b want 0010", bus.s_we);
      end
      @(negedge clk);
      total++;
      if (bus.m_ready !== 2'b01) begin
         bad++; $display("FAIL rstmid_m0_ready: got %b want 01", bus.m_ready);
      end
      @(posedge clk); #1;
      bus.m_req = '0;
   endtask

   // Masters issue random accesses with random gaps and occasional abandonment;
   // the model grants at IDLE sample points and predicts strobe/ready timing.
   task automatic test_random(input int ncyc);
      logic [NM-1:0]  req;
      logic [NM-1:0]  we_a;
      logic [7:0]     addr_a [NM];
      logic [1:0]     wd_a [NM];
      logic [31:0]    dat_a [NM];
      int             gap [NM];
      int             served [NM];
      int             idle_from, acc_cyc, resp_cyc, last, gnt, c;
      logic           cap_we, start, found;
      logic [1:0]     cap_id;
      logic [39:0]    cap_lb;
      logic [31:0]    hold, exp_rdata;
      logic [9:0]     exp_out;
      logic [NM-1:0]  one_m;
      do_reset();
      one_m = 1;
      req = '0; we_a = '0;
      idle_from = 0; acc_cyc = -10; resp_cyc = -10; last = NM - 1; gnt = 0;
      cap_we = 1'b0; cap_id = '0; cap_lb = '0; hold = '0;
      for (int m = 0; m < NM; m++) begin
         gap[m] = $urandom_range(0, 3); served[m] = 0;
         addr_a[m] = '0; wd_a[m] = '0; dat_a[m] = '0;
      end
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk);
         if (k >= 1 && k - 1 >= idle_from && req != '0) begin
            found = 1'b0;
            for (int i = 1; i <= NM; i++) begin
               c = (last + i) % NM;
               if (!found && req[c]) begin found = 1'b1; gnt = c; end
            end
            cap_we = we_a[gnt]; cap_id = addr_a[gnt][7:6];
            cap_lb = {addr_a[gnt][5:0], wd_a[gnt], dat_a[gnt]};
            acc_cyc = k; resp_cyc = k + 1; idle_from = k + 2;
         end
         #1;
         for (int m = 0; m < NM; m++) begin
            start = 1'b0;
            if (req[m]) begin
               if (k - 1 == resp_cyc && gnt == m) begin
                  served[m]++;
                  if ($urandom_range(0, 1) == 1) start = 1'b1;
                  else begin req[m] = 1'b0; gap[m] = $urandom_range(0, 4); end
               end else if (!(gnt == m && k >= acc_cyc && k <= resp_cyc) && $urandom_range(0, 15) == 0) begin
                  req[m] = 1'b0; gap[m] = $urandom_range(0, 4);
               end
            end else if (gap[m] == 0) start = 1'b1;
            else gap[m]--;
            if (start) begin
               req[m] = 1'b1; we_a[m] = 1'($urandom);
               addr_a[m] = 8'($urandom); wd_a[m] = 2'($urandom); dat_a[m] = $urandom;
            end
            bus.m_we[m] = we_a[m]; bus.m_addr[m] = addr_a[m];
            bus.m_write_width[m] = wd_a[m]; bus.m_wdata[m] = dat_a[m];
         end
         bus.m_req = req;
         for (int s = 0; s < 4; s++) bus.s_rdata[s] = $urandom;
         @(negedge clk);
         exp_out = '0;
         if (k == acc_cyc && cap_we)  exp_out[5:2] = 4'b0001 << cap_id;
         if (k == acc_cyc && !cap_we) exp_out[9:6] = 4'b0001 << cap_id;
         if (k == resp_cyc) exp_out[1:0] = one_m << gnt;
         exp_rdata = (k == resp_cyc) ? (cap_we ? 32'h0 : bus.s_rdata[cap_id]) : hold;
         total++;
         if ({bus.s_re, bus.s_we, bus.m_ready} !== exp_out) begin
            bad++; $display("FAIL rand_strobe_ready cyc%0d: got %h want %h", k, {bus.s_re, bus.s_we, bus.m_ready}, exp_out);
         end
         total++;
         if (bus.m_rdata !== exp_rdata) begin
            bad++; $display("FAIL rand_rdata cyc%0d: got %h want %h", k, bus.m_rdata, exp_rdata);
         end
         total++;
         if (bus.lb_slave !== cap_lb) begin
            bad++; $display("FAIL rand_lb_slave cyc%0d: got %h want %h", k, bus.lb_slave, cap_lb);
         end
         if (k == resp_cyc) begin hold = exp_rdata; last = gnt; end
      end
      for (int m = 0; m < NM; m++) begin
         total++;
         if (served[m] == 0) begin
            bad++; $display("FAIL rand_served_m%0d: got 0 accesses want >0", m);
         end
      end
      @(posedge clk); #1;
      bus.m_req = '0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_single_write();
      test_single_read();
      test_contention();
      test_late_request();
      test_reset_mid();
      test_random(2000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
